zx_tape_player: RTL

//  Tape engine for the ZX80/ZX81 core, successor to the fixed fast-load tape path.

---
 rtl/zx_tape_player.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/zx_tape_player.sv
// zx_tape_player: tape engine for the ZX80/ZX81 core.
// Reads a .o/.p image from the tape buffer. FAST mode copies it into RAM, one
// byte per ce tick. REAL mode replays it as a ZX81 pulse stream on tape_out.
module zx_tape_player #(
  parameter int unsigned ADDR_W      = 14,
  parameter logic [15:0] BASE_ADDR   = 16'h4000,
  parameter int unsigned P_OFFSET    = 9,
  parameter int unsigned PULSE_TICKS = 975,
  parameter int unsigned GAP_TICKS   = 8450,
  parameter int unsigned LEAD_TICKS  = 3250000,
  parameter logic [7:0]  NAME_BYTE   = 8'h80
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ce,
  input  logic              mode,
  input  logic              fmt_p,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W:0]   tape_len,
  output logic [ADDR_W-1:0] buf_addr,
  input  logic [7:0]        buf_data,
  output logic [15:0]       ram_addr,
  output logic [7:0]        ram_data,
  output logic              ram_we,
  output logic              tape_out,
  output logic              busy,
  output logic              done
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_WRITE, S_LEAD, S_NAME, S_HI, S_LO, S_GAP, S_DONE
  } state_e;

  localparam logic [22:0] P_LD    = 23'(PULSE_TICKS - 1);
  localparam logic [22:0] G_LD    = 23'(GAP_TICKS - 1);
  localparam logic [22:0] L_LD    = 23'(LEAD_TICKS - 1);
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

  state_e            state_q;
  logic [ADDR_W-1:0] buf_addr_q;
  logic [15:0]       ram_addr_q;
  logic [7:0]        ram_data_q;
  logic              ram_we_q;
  logic              tape_out_q;
  logic              busy_q;
  logic              done_q;
  logic              fmt_q;
  logic              name_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   idx_q;
  logic [22:0]       tick_q;
  logic [3:0]        pulse_q;
  logic [2:0]        bit_q;
  logic [7:0]        byte_q;   // bits still to send, next one in [7]

  logic [ADDR_W:0]   idx_inc;
  logic [15:0]       p_off;

  assign idx_inc  = idx_q + ONE;
  assign p_off    = fmt_q ? 16'(P_OFFSET) : '0;

  assign buf_addr = buf_addr_q;
  assign ram_addr = ram_addr_q;
  assign ram_data = ram_data_q;
  assign ram_we   = ram_we_q;
  assign tape_out = tape_out_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // remaining pulses after the first one for a given bit value
  function automatic logic [3:0] pulses_for(input logic b);
    return b ? 4'd8 : 4'd3;
  endfunction

  // playback/DMA state machine with registered outputs
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      buf_addr_q <= '0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      ram_we_q   <= 1'b0;
      tape_out_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fmt_q      <= 1'b0;
      name_q     <= 1'b0;
      len_q      <= '0;
      idx_q      <= '0;
      tick_q     <= '0;
      pulse_q    <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
    end else begin
      ram_we_q <= 1'b0;
      done_q   <= 1'b0;
      if (stop) begin
        state_q    <= S_IDLE;
        tape_out_q <= 1'b0;
        busy_q     <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: if (start) begin
            fmt_q      <= fmt_p;
            name_q     <= fmt_p;
            len_q      <= tape_len;
            idx_q      <= '0;
            buf_addr_q <= '0;
            if (tape_len == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              busy_q <= 1'b1;
              if (mode) begin
                state_q <= S_LEAD;
                tick_q  <= L_LD;
              end else begin
                state_q <= S_FETCH;
              end
            end
          end
          S_FETCH: state_q <= S_WRITE;
          S_WRITE: if (ce) begin
            ram_addr_q <= BASE_ADDR + p_off + 16'(idx_q);
            ram_data_q <= buf_data;
            ram_we_q   <= 1'b1;
            idx_q      <= idx_inc;
            if (idx_inc == len_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              buf_addr_q <= idx_inc[ADDR_W-1:0];
              state_q    <= S_FETCH;
            end
          end
          S_LEAD: if (ce) begin
            if (tick_q == '0) begin
              if (name_q) begin
                state_q <= S_NAME;
              end else begin
                byte_q     <= {buf_data[6:0], 1'b0};
                bit_q      <= '0;
                pulse_q    <= pulses_for(buf_data[7]);
                tick_q     <= P_LD;
                tape_out_q <= 1'b1;
                state_q    <= S_HI;
              end
            end else begin
              tick_q <= tick_q - 23'd1;
            end
          end
          S_NAME: begin
            byte_q     <= {NAME_BYTE[6:0], 1'b0};
            bit_q      <= '0;
            pulse_q    <= pulses_for(NAME_BYTE[7]);
            tick_q     <= P_LD;
            tape_out_q <= 1'b1;
            state_q    <= S_HI;
          end
          S_HI: if (ce) begin
            if (tick_q == '0) begin
              tape_out_q <= 1'b0;
              tick_q     <= P_LD;
              state_q    <= S_LO;
            end else begin
              tick_q <= tick_q - 23'd1;
            end
          end
          S_LO: if (ce) begin
            if (tick_q == '0) begin
              if (pulse_q == '0) begin
                tick_q  <= G_LD;
                state_q <= S_GAP;
                // LSB gap: prefetch the next data byte (name byte does not consume one)
                if (bit_q == 3'd7 && !name_q) begin
                  idx_q      <= idx_inc;
                  buf_addr_q <= idx_inc[ADDR_W-1:0];
                end
              end else begin
                pulse_q    <= pulse_q - 4'd1;
                tick_q     <= P_LD;
                tape_out_q <= 1'b1;
                state_q    <= S_HI;
              end
            end else begin
              tick_q <= tick_q - 23'd1;
            end
          end
          S_GAP: if (ce) begin
            if (tick_q == '0) begin
              if (bit_q != 3'd7) begin
                bit_q      <= bit_q + 3'd1;
                byte_q     <= {byte_q[6:0], 1'b0};
                pulse_q    <= pulses_for(byte_q[7]);
                tick_q     <= P_LD;
                tape_out_q <= 1'b1;
                state_q    <= S_HI;
              end else if (!name_q && idx_q == len_q) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end else begin
                name_q     <= 1'b0;
                byte_q     <= {buf_data[6:0], 1'b0};
                bit_q      <= '0;
                pulse_q    <= pulses_for(buf_data[7]);
                tick_q     <= P_LD;
                tape_out_q <= 1'b1;
                state_q    <= S_HI;
              end
            end else begin
              tick_q <= tick_q - 23'd1;
            end
          end
          S_DONE: state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule
